// File: rtl/alu_div_seq.sv
// alu_div_seq: iterative restoring divider that borrows the shared integer ALU.
// While an operation is in flight the block owns the ALU muxes. Each quotient
// bit takes two ALU cycles: a compare (SGEU) followed by a subtract (SUB).
// Optional feature macro: DIV_SIGNED_EN adds signed DIV/REM. It takes operand
// magnitudes on accept and applies the sign fix-up on entry to DONE.

package alu_div_pkg;
  typedef enum logic [3:0] {
    ALU_NOP  = 4'd0,
    ALU_ADD  = 4'd1,
    ALU_SUB  = 4'd2,
    ALU_SGEU = 4'd3
  } alu_op_t;
endpackage

module alu_div_seq
  import alu_div_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int DIV0_FAST = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             flush,
  output logic             alu_own,
  output alu_op_t          alu_op,
  output logic [WIDTH-1:0] alu_src1,
  output logic [WIDTH-1:0] alu_src2,
  input  logic [WIDTH-1:0] alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  typedef enum logic [1:0] {S_IDLE, S_CMP, S_SUB, S_DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] rem, quo;
  logic [4:0]       cnt;
  logic             ge_q;

  logic             ge;
  logic [WIDTH-1:0] rem_nxt, quo_nxt, rem_sh_nxt;
  logic [WIDTH-1:0] a_mag, b_mag, q_fix, r_fix;

  // Bit 31 of the old remainder is the 33rd bit of the shifted remainder.
  // When it is set, the shifted value is always >= divisor, and the
  // 32-bit wrap of SUB still gives the exact difference.
  assign ge         = alu_result[0] | rem[WIDTH-1];
  assign rem_nxt    = ge_q ? alu_result : {rem[WIDTH-2:0], quo[WIDTH-1]};
  assign quo_nxt    = {quo[WIDTH-2:0], ge_q};
  assign rem_sh_nxt = {rem_nxt[WIDTH-2:0], quo_nxt[WIDTH-1]};

`ifdef DIV_SIGNED_EN
  logic a_neg, b_neg, neg_q, neg_r, div0_q;
  assign a_neg = req_signed & dividend[WIDTH-1];
  assign b_neg = req_signed & divisor[WIDTH-1];
  assign a_mag = a_neg ? -dividend : dividend;
  assign b_mag = b_neg ? -divisor  : divisor;
  // Divide by zero keeps quotient = -1 whatever the operand signs are.
  // Negating the remainder magnitude brings the raw dividend back.
  assign q_fix = div0_q ? '1 : (neg_q ? -quo_nxt : quo_nxt);
  assign r_fix = neg_r ? -rem_nxt : rem_nxt;

  // Sign bookkeeping is captured at accept time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0_q <= 1'b0;
    end else if (state == S_IDLE && req_valid && !flush) begin
      neg_q  <= a_neg ^ b_neg;
      neg_r  <= a_neg;
      div0_q <= (divisor == '0);
    end
  end
`else
  logic unused_sign;
  assign unused_sign = req_signed;
  assign a_mag = dividend;
  assign b_mag = divisor;
  assign q_fix = quo_nxt;
  assign r_fix = rem_nxt;
`endif

  // Sequencer FSM. All handshake and ALU-mux outputs are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      alu_own   <= 1'b0;
      alu_op    <= ALU_NOP;
      alu_src1  <= '0;
      alu_src2  <= '0;
      quotient  <= '0;
      remainder <= '0;
      rem       <= '0;
      quo       <= '0;
      cnt       <= '0;
      ge_q      <= 1'b0;
    end else if (flush) begin
      state     <= S_IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      alu_own   <= 1'b0;
      alu_op    <= ALU_NOP;
    end else begin
      unique case (state)
        S_IDLE: if (req_valid) begin
          req_ready <= 1'b0;
          rem       <= '0;
          quo       <= a_mag;
          cnt       <= 5'd31;
          if (DIV0_FAST != 0 && divisor == '0) begin
            state     <= S_DONE;
            rsp_valid <= 1'b1;
            quotient  <= '1;
            remainder <= dividend;
          end else begin
            state    <= S_CMP;
            alu_own  <= 1'b1;
            alu_op   <= ALU_SGEU;
            alu_src1 <= {{(WIDTH-1){1'b0}}, a_mag[WIDTH-1]};
            alu_src2 <= b_mag;
          end
        end
        S_CMP: begin
          ge_q   <= ge;
          alu_op <= ALU_SUB;
          state  <= S_SUB;
        end
        S_SUB: begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          if (cnt == 5'd0) begin
            state     <= S_DONE;
            alu_own   <= 1'b0;
            alu_op    <= ALU_NOP;
            rsp_valid <= 1'b1;
            quotient  <= q_fix;
            remainder <= r_fix;
          end else begin
            cnt      <= cnt - 5'd1;
            state    <= S_CMP;
            alu_op   <= ALU_SGEU;
            alu_src1 <= rem_sh_nxt;
          end
        end
        S_DONE: if (rsp_ready) begin
          state     <= S_IDLE;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_div_seq.sv
// Directed bench for alu_div_seq with a behavioural ALU.
// Expected results go into a scoreboard queue at request time and are popped
// when the response appears.
module tb_alu_div_seq;
  import alu_div_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_signed = 1'b0, flush = 1'b0, rsp_ready = 1'b0;
  logic [31:0] dividend = '0, divisor = '0;
  logic        req_ready, alu_own, rsp_valid;
  alu_op_t     alu_op;
  logic [31:0] alu_src1, alu_src2, alu_result, quotient, remainder;

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] sb_q[$];
  logic [31:0] sb_r[$];

  alu_div_seq dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_signed(req_signed), .dividend(dividend), .divisor(divisor), .flush(flush),
    .alu_own(alu_own), .alu_op(alu_op), .alu_src1(alu_src1), .alu_src2(alu_src2),
    .alu_result(alu_result), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .quotient(quotient), .remainder(remainder)
  );

  // Shared integer ALU stand-in.
  always_comb begin
    alu_result = '0;
    if (alu_op == ALU_SUB)       alu_result = alu_src1 - alu_src2;
    else if (alu_op == ALU_SGEU) alu_result = {31'd0, alu_src1 >= alu_src2};
  end

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Full request/response transaction. The bench sits on negedges throughout.
  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic sg, input logic [31:0] eq, input logic [31:0] er,
                         input int exp_busy, input bit hold);
    int cyc = 0;
    bit alt_ok = 1'b1;
    logic [31:0] wq, wr;
    while (!req_ready && cyc < 200) begin @(negedge clk); cyc++; end
    chk({tag, " req_ready"}, {31'd0, req_ready}, 32'd1);
    sb_q.push_back(eq); sb_r.push_back(er);
    req_valid = 1'b1; dividend = a; divisor = b; req_signed = sg;
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 0;
    while (!rsp_valid && cyc < 200) begin
      if (!alu_own || alu_op !== ((cyc % 2 == 0) ? ALU_SGEU : ALU_SUB)) alt_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
    chk({tag, " latency"}, cyc, exp_busy);
    chk({tag, " alu_alt"}, {31'd0, alt_ok}, 32'd1);
    chk({tag, " own_done"}, {31'd0, alu_own}, 32'd0);
    wq = sb_q.pop_front(); wr = sb_r.pop_front();
    chk({tag, " quotient"}, quotient, wq);
    chk({tag, " remainder"}, remainder, wr);
    if (hold) begin
      // Requests arriving while a response waits are dropped.
      req_valid = 1'b1; dividend = 32'd77; divisor = 32'd5;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        chk({tag, " hold_q"}, quotient, wq);
        chk({tag, " hold_r"}, remainder, wr);
        chk({tag, " hold_rdy"}, {31'd0, req_ready}, 32'd0);
        chk({tag, " hold_vld"}, {31'd0, rsp_valid}, 32'd1);
      end
      req_valid = 1'b0;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, " vld_drop"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, " rdy_back"}, {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] ra, rb;
    #12;
    chk("rst req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst alu_own", {31'd0, alu_own}, 32'd0);
    chk("rst alu_op", 32'(alu_op), 32'(ALU_NOP));
    chk("rst quotient", quotient, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    run_div("100/7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 64, 1'b0);
    run_div("ffff/1", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 64, 1'b0);
    run_div("5/0", 32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5, 0, 1'b0);
    run_div("0/0", 32'd0, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'd0, 0, 1'b0);
    run_div("7/9", 32'd7, 32'd9, 1'b0, 32'd0, 32'd7, 64, 1'b0);
    run_div("ff/ff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd1, 32'd0, 64, 1'b0);
    run_div("big/3", 32'h8000_0001, 32'd3, 1'b0, 32'h2AAA_AAAB, 32'd0, 64, 1'b0);
`ifdef DIV_SIGNED_EN
    run_div("s-7/2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 64, 1'b0);
    run_div("s7/-2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 64, 1'b0);
    run_div("smin/-1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 64, 1'b0);
    run_div("s-5/0", 32'hFFFF_FFFB, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 0, 1'b0);
`else
    run_div("u-7/2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'h7FFF_FFFC, 32'd1, 64, 1'b0);
    run_div("umin/-1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'h8000_0000, 64, 1'b0);
`endif
    for (int k = 0; k < 4; k++) begin
      ra = $urandom;
      rb = $urandom_range(1, 100000);
      if (k == 3) rb = $urandom | 32'h8000_0000;
      run_div("rand", ra, rb, 1'b0, ra / rb, ra % rb, 64, 1'b0);
    end

    // Flush at the CMP of bit 10; a simultaneous request must lose.
    req_valid = 1'b1; dividend = 32'd1000; divisor = 32'd3; req_signed = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 42; i++) @(negedge clk);
    chk("flush at_cmp", 32'(alu_op), 32'(ALU_SGEU));
    flush = 1'b1; req_valid = 1'b1; dividend = 32'd50; divisor = 32'd5;
    @(negedge clk);
    flush = 1'b0; req_valid = 1'b0;
    chk("flush rdy", {31'd0, req_ready}, 32'd1);
    chk("flush own", {31'd0, alu_own}, 32'd0);
    chk("flush vld", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    chk("flush ignored", {31'd0, alu_own | rsp_valid}, 32'd0);
    run_div("9/3", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 64, 1'b0);

    run_div("hold", 32'd1234, 32'd10, 1'b0, 32'd123, 32'd4, 64, 1'b1);

    // Asynchronous reset in the middle of an operation.
    req_valid = 1'b1; dividend = 32'd12345; divisor = 32'd17;
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 20; i++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst rdy", {31'd0, req_ready}, 32'd1);
    chk("arst own", {31'd0, alu_own}, 32'd0);
    chk("arst op", 32'(alu_op), 32'(ALU_NOP));
    chk("arst src1", alu_src1, 32'd0);
    chk("arst src2", alu_src2, 32'd0);
    chk("arst q", quotient, 32'd0);
    chk("arst r", remainder, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("arst vld", {31'd0, rsp_valid}, 32'd0);
    run_div("post_rst", 32'd64, 32'd8, 1'b0, 32'd8, 32'd0, 64, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
